id_ex_pipeline_reg: RTL
=======================

// Module: id_ex_pipeline_reg
// PURPOSE
//  ID/EX pipeline register directly downstream of the decode/control stage. Captures decoded control
//  bundle, operands, immediate, PC and register addresses each cycle and presents them to EX.
//  Implements stall hold, flush bubble and load-use bubble insertion; drives load_use_stall back to IF/ID.
// PARAMETERS
//  XLEN      32  datapath width (pc, rs1/rs2 data, imm)
//  CTRL_W    17  width of packed control bundle (fixed by packing below; do not override)
// PORTS
//  clk             in   1       rising-edge clock
//  rst_n           in   1       asynchronous active-low reset
//  stall_i         in   1       downstream stall: hold all EX outputs
//  flush_i         in   1       branch/jump redirect: kill instruction entering EX
//  id_valid_i      in   1       ID stage holds a real instruction
//  id_ctrl_i       in   CTRL_W  {reg_write,mem_to_reg,mem_write,mem_read,branch,alu_src,alu_src_b[1:0],
//                               jump[1:0],alu_op[3:0],funct3[2:0]} MSB..LSB, from control unit
//  id_pc_i         in   XLEN    PC of ID instruction
//  id_rs1_data_i   in   XLEN    register-file read port 1
//  id_rs2_data_i   in   XLEN    register-file read port 2
//  id_imm_i        in   XLEN    sign-extended immediate
//  id_rs1_i        in   5       source register 1 address
//  id_rs2_i        in   5       source register 2 address
//  id_rd_i         in   5       destination register address
//  ex_valid_o      out  1       EX holds a real instruction
//  ex_ctrl_o       out  CTRL_W  registered control bundle (same packing)
//  ex_pc_o / ex_rs1_data_o / ex_rs2_data_o / ex_imm_o   out  XLEN  registered copies
//  ex_rs1_o / ex_rs2_o / ex_rd_o                        out  5     registered copies
//  load_use_stall_o out 1       combinational: hold PC and IF/ID this cycle
// BEHAVIOUR
//  - Reset (rst_n=0, async): every registered output = 0; ex_valid_o=0. load_use_stall_o=0 follows.
//  - Latency: 1 cycle ID->EX. Per rising edge, priority: flush_i > stall_i > load-use > load.
//    flush_i=1: ex_valid_o<=0, ex_ctrl_o<=0 (bubble); data/address outputs <=0.
//    stall_i=1 (no flush): all registers hold; load_use_stall_o still evaluated but bubble not inserted.
//    load_use_stall_o=1 (no flush/stall): bubble inserted exactly as flush.
//    else: all registers <= id_* inputs; ex_valid_o<=id_valid_i; if id_valid_i=0, ex_ctrl_o<=0.
//  - Invariant: ex_valid_o=0 implies ex_ctrl_o=0 (no reg_write/mem_write/mem_read/branch/jump leaks).
//  - Load-use detect: load_use_stall_o = ex_valid_o & ex_mem_read & (ex_rd_o!=0) & id_valid_i &
//    ((rs1_used & ex_rd_o==id_rs1_i) | (rs2_used & ex_rd_o==id_rs2_i)).
//    rs1_used = !(alu_src_b!=2'b00 | jump==2'b01)  (excludes LUI, AUIPC, JAL).
//    rs2_used = !alu_src | mem_write | branch       (R-type, stores, branches).
//  - Bubble lasts exactly one cycle: after it, ex_valid_o=0 so detect deasserts and ID re-issues.
//  - x0 destination never triggers a stall. flush_i in same cycle as detect: flush wins, stall output
//    is still high that cycle (IF/ID is flushed upstream anyway).
//  - Reset asserted mid-stall: outputs clear immediately; detect drops combinationally.
// CONFIGURATION
//  ID_EX_LOAD_USE_DETECT_EN defined: load-use detection and bubble insertion as above.
//  Not defined: load_use_stall_o tied 0; register obeys flush_i > stall_i > load only; hazards
//  must then be resolved externally (software NOPs or separate hazard unit).
// TESTING
//  1 Reset: drive rst_n=0 mid-cycle with valid data loaded -> all ex_* =0 immediately, no clk edge needed.
//  2 Pass-through: id ADD x3,x1,x2 (ctrl alu_op=0000, reg_write=1), pc=0x100 -> next edge ex_pc_o=0x100,
//    ex_rd_o=3, ex_ctrl_o equals input, ex_valid_o=1.
//  3 Load-use: EX=LW x5 (mem_read=1, rd=5), ID=ADD x6,x5,x1 -> load_use_stall_o=1; next edge
//    ex_valid_o=0, ex_ctrl_o=0; following edge ADD enters EX, stall=0. Repeat with rd=0 -> no stall.
//  4 Rs usage: EX=LW x5; ID=LUI x5 or ADDI x7,x1,5 with rs2 field=5 -> no stall; ID=SW x5,0(x1) -> stall.
//  5 Priority: stall_i=1 with changing id_* -> outputs hold 3 cycles; flush_i+stall_i together -> bubble.
//  6 Macro off: scenario 3 -> load_use_stall_o=0, ADD enters EX next edge with ex_valid_o=1.

Source files
------------

// File: rtl/id_ex_pipeline_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipeline_reg
// Description : ID/EX pipeline register placed directly after the
//               decode/control stage. It captures the decoded control bundle,
//               the operands, the immediate, the PC and the register addresses,
//               and presents them to EX one cycle later. It supports:
//                 - holding its contents while EX is stalled,
//                 - inserting a bubble when a branch or jump redirects (flush),
//                 - inserting a bubble when a load-use hazard is detected,
//                   and driving load_use_stall_o back to IF/ID.
//
// Parameters  : XLEN    datapath width (pc, rs1/rs2 data, imm)
//               CTRL_W  packed control bundle width. The bundle layout is
//                       fixed at 17 bits, so this must not be overridden:
//                       {reg_write, mem_to_reg, mem_write, mem_read, branch,
//                        alu_src, alu_src_b[1:0], jump[1:0], alu_op[3:0],
//                        funct3[2:0]}  (MSB..LSB)
//
// Ports       : clk, rst_n             clock, asynchronous active-low reset
//               stall_i                downstream stall: hold every EX output
//               flush_i                redirect: kill the instruction entering EX
//               id_valid_i             ID holds a real instruction
//               id_ctrl_i              control bundle from the control unit
//               id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i
//                                      XLEN-wide datapath values from ID
//               id_rs1_i, id_rs2_i, id_rd_i
//                                      5-bit register addresses from ID
//               ex_valid_o             EX holds a real instruction
//               ex_ctrl_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
//               ex_rs1_o, ex_rs2_o, ex_rd_o
//                                      registered copies presented to EX
//               load_use_stall_o       combinational: hold PC and IF/ID now
//
// Build macro : ID_EX_LOAD_USE_DETECT_EN
//               When defined, load-use detection and bubble insertion are
//               enabled. When undefined, load_use_stall_o is tied to 0 and the
//               register obeys only flush_i > stall_i > load. Hazards must
//               then be resolved externally.
//
// Revision    : 1.0  initial release
// ============================================================================
module id_ex_pipeline_reg #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic [XLEN-1:0]   id_pc_i,
    input  logic [XLEN-1:0]   id_rs1_data_i,
    input  logic [XLEN-1:0]   id_rs2_data_i,
    input  logic [XLEN-1:0]   id_imm_i,
    input  logic [4:0]        id_rs1_i,
    input  logic [4:0]        id_rs2_i,
    input  logic [4:0]        id_rd_i,
    output logic              ex_valid_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic [XLEN-1:0]   ex_pc_o,
    output logic [XLEN-1:0]   ex_rs1_data_o,
    output logic [XLEN-1:0]   ex_rs2_data_o,
    output logic [XLEN-1:0]   ex_imm_o,
    output logic [4:0]        ex_rs1_o,
    output logic [4:0]        ex_rs2_o,
    output logic [4:0]        ex_rd_o,
    output logic              load_use_stall_o
);

    logic load_use_stall;
    logic bubble;

`ifdef ID_EX_LOAD_USE_DETECT_EN
    // Bit positions inside the packed control bundle.
    localparam int CTRL_MEM_WRITE     = 14;
    localparam int CTRL_MEM_READ      = 13;
    localparam int CTRL_BRANCH        = 12;
    localparam int CTRL_ALU_SRC       = 11;
    localparam int CTRL_ALU_SRC_B_LSB = 9;
    localparam int CTRL_JUMP_LSB      = 7;

    logic [1:0] id_alu_src_b;
    logic [1:0] id_jump;
    logic       id_alu_src;
    logic       id_mem_write;
    logic       id_branch;
    logic       ex_mem_read;
    logic       rs1_used;
    logic       rs2_used;
    logic       rd_live;
    logic       rs1_hit;
    logic       rs2_hit;

    always_comb begin
        id_alu_src_b = id_ctrl_i[CTRL_ALU_SRC_B_LSB +: 2];
        id_jump      = id_ctrl_i[CTRL_JUMP_LSB +: 2];
        id_alu_src   = id_ctrl_i[CTRL_ALU_SRC];
        id_mem_write = id_ctrl_i[CTRL_MEM_WRITE];
        id_branch    = id_ctrl_i[CTRL_BRANCH];
        ex_mem_read  = ex_ctrl_o[CTRL_MEM_READ];

        // LUI/AUIPC select a non-register A operand and JAL ignores rs1, so
        // the rs1 field of those instructions holds immediate bits and must
        // not be treated as a dependency.
        rs1_used = !((id_alu_src_b != 2'b00) || (id_jump == 2'b01));
        // rs2 is only read when the ALU takes its B operand from a register,
        // or when it is store data or a branch comparand.
        rs2_used = !id_alu_src || id_mem_write || id_branch;

        // A load into x0 is architecturally discarded, so it never blocks.
        rd_live = ex_valid_o && ex_mem_read && (ex_rd_o != 5'd0);
        rs1_hit = rs1_used && (ex_rd_o == id_rs1_i);
        rs2_hit = rs2_used && (ex_rd_o == id_rs2_i);

        // This stays visible even under flush or stall. When a flush is in
        // progress the upstream stages are being killed anyway.
        load_use_stall = rd_live && id_valid_i && (rs1_hit || rs2_hit);
    end
`else
    assign load_use_stall = 1'b0;
`endif

    // A flush always wins. A load-use bubble is only inserted when EX is
    // free to advance. Once the bubble is inserted, ex_valid_o is 0, so
    // detection drops and ID re-issues on the following edge.
    assign bubble = flush_i || (!stall_i && load_use_stall);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_o    <= 1'b0;
            ex_ctrl_o     <= '0;
            ex_pc_o       <= '0;
            ex_rs1_data_o <= '0;
            ex_rs2_data_o <= '0;
            ex_imm_o      <= '0;
            ex_rs1_o      <= '0;
            ex_rs2_o      <= '0;
            ex_rd_o       <= '0;
        end else if (bubble) begin
            ex_valid_o    <= 1'b0;
            ex_ctrl_o     <= '0;
            ex_pc_o       <= '0;
            ex_rs1_data_o <= '0;
            ex_rs2_data_o <= '0;
            ex_imm_o      <= '0;
            ex_rs1_o      <= '0;
            ex_rs2_o      <= '0;
            ex_rd_o       <= '0;
        end else if (!stall_i) begin
            ex_valid_o    <= id_valid_i;
            // Zeroing the control bundle for an invalid slot keeps the
            // invariant that an invalid EX slot never carries a live
            // write/read/branch/jump.
            ex_ctrl_o     <= id_valid_i ? id_ctrl_i : '0;
            ex_pc_o       <= id_pc_i;
            ex_rs1_data_o <= id_rs1_data_i;
            ex_rs2_data_o <= id_rs2_data_i;
            ex_imm_o      <= id_imm_i;
            ex_rs1_o      <= id_rs1_i;
            ex_rs2_o      <= id_rs2_i;
            ex_rd_o       <= id_rd_i;
        end
    end

    assign load_use_stall_o = load_use_stall;

endmodule
`default_nettype wire
